// File: rtl/counter_run_arbiter.sv
// Two-requester arbiter that grants a shared up/down counter for a single run.
// A run counts from 0 up to lim, or from lim down to 0. Requesters are served round-robin.
module counter_run_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             dir0,
    input  logic [WIDTH-1:0] lim0,
    input  logic             req1,
    input  logic             dir1,
    input  logic [WIDTH-1:0] lim1,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic             done,
    output logic             done_id
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             dir_q, dir_d;
    logic             owner_q, owner_d;
    logic             ptr_q, ptr_d;
    logic             done_id_q, done_id_d;
    logic [1:0]       grant_q, grant_d;
    logic             winner;
    logic             owner_req;
    logic [WIDTH-1:0] target;

    // ptr_q holds the index served last; on a tie the other requester wins.
    assign winner    = (req0 && req1) ? ~ptr_q : req1;
    assign owner_req = owner_q ? req1 : req0;
    assign target    = dir_q ? lim_q : '0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lim_d     = lim_q;
        dir_d     = dir_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        done_id_d = done_id_q;
        grant_d   = grant_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = RUN;
                    owner_d = winner;
                    grant_d = winner ? 2'b10 : 2'b01;
                    dir_d   = winner ? dir1 : dir0;
                    lim_d   = winner ? lim1 : lim0;
                    cnt_d   = (winner ? dir1 : dir0) ? '0 : (winner ? lim1 : lim0);
                end
            end
            RUN: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    ptr_d   = owner_q;
                end else if (cnt_q == target) begin
                    state_d   = DONE;
                    grant_d   = 2'b00;
                    ptr_d     = owner_q;
                    done_id_d = owner_q;
                end else begin
                    cnt_d = dir_q ? (cnt_q + ONE) : (cnt_q - ONE);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lim_q     <= '0;
            dir_q     <= 1'b0;
            owner_q   <= 1'b0;
            ptr_q     <= 1'b1;
            done_id_q <= 1'b0;
            grant_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lim_q     <= lim_d;
            dir_q     <= dir_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            done_id_q <= done_id_d;
            grant_q   <= grant_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign q       = cnt_q;
    assign done_id = done_id_q;

endmodule

// File: tb/tb_counter_run_arbiter.sv
// Scoreboard bench for counter_run_arbiter: stimulus queues the expected busy/done
// cycles, and a monitor compares them whenever the DUT is busy or signalling done.
module tb_counter_run_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, dir0, req1, dir1;
    logic [3:0] lim0, lim1;
    logic [1:0] grant;
    logic       busy, done, done_id;
    logic [3:0] q;

    typedef struct {
        logic       is_done;
        logic [1:0] grant;
        logic [3:0] q;
        logic       id;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    counter_run_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .dir0(dir0), .lim0(lim0),
        .req1(req1), .dir1(dir1), .lim1(lim1),
        .grant(grant), .busy(busy), .q(q), .done(done), .done_id(done_id)
    );

    always #5 clk = ~clk;

    task automatic push_run(input logic [1:0] g, input int from, input int to);
        exp_t x;
        int step;
        step = (to >= from) ? 1 : -1;
        for (int v = from; ; v += step) begin
            x.is_done = 1'b0; x.grant = g; x.q = 4'(v); x.id = 1'b0;
            sb.push_back(x);
            if (v == to) break;
        end
    endtask

    task automatic push_done(input logic id, input int qv);
        exp_t x;
        x.is_done = 1'b1; x.grant = 2'b00; x.q = 4'(qv); x.id = id;
        sb.push_back(x);
    endtask

    // Idle/reset check of {q, grant, busy, done}.
    task automatic check_idle(input string name, input logic [3:0] exp_q);
        logic [7:0] got, exp;
        got = {q, grant, busy, done};
        exp = {exp_q, 2'b00, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got q=%0d grant=%b busy=%b done=%b expected q=%0d grant=00 busy=0 done=0",
                     name, q, grant, busy, done, exp_q);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every busy or done cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && (busy === 1'b1 || done === 1'b1)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output busy=%b done=%b grant=%b q=%0d done_id=%b",
                         busy, done, grant, q, done_id);
            end else begin
                e = sb.pop_front();
                if ({busy, done, grant, q, (done ? done_id : 1'b0)} !==
                    {~e.is_done, e.is_done, e.grant, e.q, (e.is_done ? e.id : 1'b0)}) begin
                    errors++;
                    $display("FAIL %s got busy=%b done=%b grant=%b q=%0d id=%b expected busy=%b done=%b grant=%b q=%0d id=%b",
                             e.is_done ? "done_cycle" : "run_cycle", busy, done, grant, q, done_id,
                             ~e.is_done, e.is_done, e.grant, e.q, e.id);
                end else begin
                    $display("txn %s grant=%b q=%0d id=%b", e.is_done ? "done" : "run ", grant, q, done_id);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        req0 = 1'b1; dir0 = 1'b1; lim0 = 4'd1;
        req1 = 1'b1; dir1 = 1'b1; lim1 = 4'd1;
        #1;
        check_idle("reset_immediate", 4'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("reset_held", 4'd0);
        end

        // Contention from reset release: alternating grants, pointer starts at req0.
        for (int r = 0; r < 4; r++) begin
            push_run((r % 2 == 0) ? 2'b01 : 2'b10, 0, 1);
            push_done(1'(r % 2), 1);
        end
        rst = 1'b1;
        cycles(15);
        req0 = 1'b0; req1 = 1'b0;
        cycles(2);

        // Up run 0..5; mid-run dir/lim changes must be ignored.
        push_run(2'b01, 0, 5);
        push_done(1'b0, 5);
        req0 = 1'b1; dir0 = 1'b1; lim0 = 4'd5;
        cycles(3);
        dir0 = 1'b0; lim0 = 4'd2;
        cycles(4);
        req0 = 1'b0; dir0 = 1'b1; lim0 = 4'd5;
        cycles(2);

        // Down run 3..0 on requester 1.
        push_run(2'b10, 3, 0);
        push_done(1'b1, 0);
        req1 = 1'b1; dir1 = 1'b0; lim1 = 4'd3;
        cycles(5);
        req1 = 1'b0;
        cycles(2);

        // Abort at q = 2: counter holds, no done pulse follows.
        push_run(2'b01, 0, 2);
        req0 = 1'b1; dir0 = 1'b1; lim0 = 4'd9;
        cycles(3);
        req0 = 1'b0;
        cycles(1);
        check_idle("abort_idle", 4'd2);
        cycles(1);
        check_idle("abort_hold", 4'd2);

        // Asynchronous reset between edges at q = 4.
        push_run(2'b10, 0, 4);
        req1 = 1'b1; dir1 = 1'b1; lim1 = 4'd9;
        cycles(5);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check_idle("async_reset_midrun", 4'd0);
        req1 = 1'b0;
        #1 rst = 1'b1;
        cycles(2);
        check_idle("after_async_reset", 4'd0);

        // lim = 0: one RUN cycle then done.
        push_run(2'b01, 0, 0);
        push_done(1'b0, 0);
        req0 = 1'b1; dir0 = 1'b1; lim0 = 4'd0;
        cycles(2);
        req0 = 1'b0;
        cycles(3);
        check_idle("final_idle", 4'd0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained got %0d pending expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_run_arbiter.md
COUNTER_RUN_ARBITER -- requirements
Module: counter_run_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the counter width.
REQ-002 The block SHALL have port clk, input, 1, single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req0, input, 1, requester 0 run request (level, held until done).
REQ-005 The block SHALL have port dir0, input, 1, requester 0 direction (1 up, 0 down).
REQ-006 The block SHALL have port lim0, input, WIDTH, requester 0 limit value.
REQ-007 The block SHALL have ports req1, dir1 and lim1, identical in direction, width and meaning to req0, dir0 and lim0, for requester 1.
REQ-008 The block SHALL have port grant, output, 2, registered one-hot owner of the counter (bit0 = req0).
REQ-009 The block SHALL have port busy, output, 1, high while a run is in progress.
REQ-010 The block SHALL have port q, output, WIDTH, registered shared counter value.
REQ-011 The block SHALL have port done, output, 1, one-cycle run-complete pulse.
REQ-012 The block SHALL have port done_id, output, 1, requester index of the last completed run.

Function
REQ-013 The block SHALL implement the FSM states IDLE, RUN and DONE, with busy = (state == RUN).
REQ-014 In IDLE with any req high, the block SHALL pick a winner at the next edge, enter RUN and set grant to the winner's one-hot value.
REQ-015 At the same edge, the block SHALL latch the winner's dir and lim and load q with 0 for an up run or lim for a down run.
REQ-016 With only one req high, that requester SHALL win.
REQ-017 With both req high, the winner SHALL be the requester opposite the round-robin pointer's last-served index.
REQ-018 After reset, the round-robin pointer SHALL favour req0.
REQ-019 In RUN, each edge SHALL compare q to the target (latched lim for up, 0 for down).
REQ-020 On a match, the next edge SHALL enter DONE with q held; otherwise q SHALL change by +1 (up) or -1 (down).
REQ-021 A run SHALL occupy exactly lim+1 RUN cycles, lim = 0 included (one RUN cycle, then DONE).
REQ-022 q SHALL never wrap; the counter stops at the target.
REQ-023 In DONE, the block SHALL drive done = 1 and done_id = winner, clear grant to 00, point the pointer at the winner, and return to IDLE on the next edge.
REQ-024 If the granted req drops during RUN, the block SHALL go to IDLE on the next edge with done = 0, q held, grant = 00, and the pointer set to the aborted requester.
REQ-025 Changes to dir or lim of either requester during RUN or DONE SHALL be ignored.
REQ-026 The non-granted req SHALL be ignored until IDLE.
REQ-027 A req still high in DONE SHALL be re-arbitrated from IDLE, with no back-to-back grant when the other requester is also high.
REQ-028 Minimum spacing between runs SHALL be DONE -> IDLE -> RUN, i.e. 2 cycles with busy = 0.

Reset
REQ-029 rst = 0 SHALL immediately, without a clock edge, force state IDLE, q = 0, grant = 00, busy = 0, done = 0, done_id = 0 and pointer favouring req0.
REQ-030 Reset asserted mid-run SHALL abort the run with no done pulse.
REQ-031 After rst rises, the first arbitration SHALL occur at the first clk edge with a req high.

Verification
REQ-032 Reset check: hold rst = 0 with clk running and req0 = req1 = 1 -> q = 0, grant = 00, busy = 0, done = 0 throughout.
REQ-033 Up run: req0 = 1, dir0 = 1, lim0 = 5 -> grant = 01 after 1 edge; q = 0,1,2,3,4,5 over 6 RUN cycles; then one cycle with done = 1, done_id = 0, grant = 00.
REQ-034 Down run: req1 = 1, dir1 = 0, lim1 = 3 -> q = 3,2,1,0; then done = 1, done_id = 1.
REQ-035 Contention: both req held high from reset release, lim0 = lim1 = 1 -> grant sequence 01, 10, 01, 10 with done_id alternating 0,1,0,1.
REQ-036 Abort: req0 up lim0 = 9, drop req0 at q = 2 -> next cycle IDLE, q = 2, grant = 00, no done pulse.
REQ-037 Async reset mid-run: assert rst = 0 between edges at q = 4 -> q = 0 and grant = 00 before the next clk edge; lim = 0 run -> exactly 1 RUN cycle then done.
